// File: rtl/pmd_ioctl_upload.sv
// HPS save-direction responder for the PMD85 ioctl channel: requests an upload and
// streams a memory window out on ioctl_din, one byte per ioctl_rd, via a req/ack arbiter port.
module pmd_ioctl_upload #(
    parameter int                ADDR_W       = 16,
    parameter logic [ADDR_W-1:0] BASE         = '0,
    parameter int                SIZE         = 32768,
    parameter logic [7:0]        UPLOAD_INDEX = 8'd1
) (
    input  logic              clk_sys,
    input  logic              reset_n,
    input  logic              save_trig,
    output logic              ioctl_upload_req,
    input  logic              ioctl_upload,
    input  logic [7:0]        ioctl_index,
    input  logic              ioctl_rd,
    output logic [7:0]        ioctl_din,
    output logic              mem_req,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic              mem_ack,
    input  logic [7:0]        mem_data,
    output logic              busy,
    output logic              overrun
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_REQ,
        ST_FETCH,
        ST_READY,
        ST_DONE
    } state_e;

    // Terminal count: the counter value after the last byte has been consumed.
    localparam logic [ADDR_W:0] LAST_CNT = (ADDR_W+1)'(SIZE);
    localparam logic [ADDR_W:0] CNT_ONE  = {{ADDR_W{1'b0}}, 1'b1};

    state_e            state_q, state_d;
    logic [ADDR_W:0]   cnt_q, cnt_d;
    logic [7:0]        din_q, din_d;
    logic              overrun_q, overrun_d;
    logic              active;
    logic [ADDR_W:0]   cnt_inc;

    assign active  = ioctl_upload && (ioctl_index == UPLOAD_INDEX);
    assign cnt_inc = cnt_q + CNT_ONE;

    // NOTE: async reset in the sensitivity list and <= for every state register so all
    // flops update together on the edge regardless of statement order.
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            din_q     <= 8'hFF;
            overrun_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            din_q     <= din_d;
            overrun_q <= overrun_d;
        end
    end

    // NOTE: every next-state signal gets its hold value first so no path leaves one
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        din_d     = din_q;
        overrun_d = overrun_q;
        case (state_q)
            ST_IDLE: begin
                if (save_trig) begin
                    state_d   = ST_REQ;
                    cnt_d     = '0;
                    overrun_d = 1'b0;
                end
            end
            ST_REQ: begin
                if (active) begin
                    state_d = ST_FETCH;
                end
            end
            ST_FETCH: begin
                // Losing the transfer wins over a same-cycle ack; that data is dropped.
                if (!active) begin
                    state_d = ST_IDLE;
                end else begin
                    if (ioctl_rd) begin
                        overrun_d = 1'b1;
                    end
                    if (mem_ack) begin
                        din_d   = mem_data;
                        state_d = ST_READY;
                    end
                end
            end
            ST_READY: begin
                if (!active) begin
                    state_d = ST_IDLE;
                end else if (ioctl_rd) begin
                    cnt_d = cnt_inc;
                    if (cnt_inc == LAST_CNT) begin
                        din_d   = 8'hFF;
                        state_d = ST_DONE;
                    end else begin
                        state_d = ST_FETCH;
                    end
                end
            end
            ST_DONE: begin
                din_d = 8'hFF;
                if (!active) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Request lines decode straight from the state register, so leaving FETCH drops mem_req on that edge.
    assign ioctl_upload_req = (state_q == ST_REQ);
    assign mem_req          = (state_q == ST_FETCH);
    assign mem_addr         = BASE + cnt_q[ADDR_W-1:0];
    assign ioctl_din        = din_q;
    assign busy             = (state_q != ST_IDLE);
    assign overrun          = overrun_q;

endmodule

// File: tb/tb_pmd_ioctl_upload.sv
// Directed bench for pmd_ioctl_upload: three instances (BASE 0 / wrapping BASE / one-byte file)
// share the ioctl stimulus, each served by its own arbiter model.
module tb_pmd_ioctl_upload;

    logic        clk_sys = 1'b0;
    logic        reset_n = 1'b0;
    logic        save_trig = 1'b0;
    logic        ioctl_upload = 1'b0;
    logic [7:0]  ioctl_index = 8'd0;
    logic        ioctl_rd = 1'b0;

    logic        upload_req [3];
    logic [7:0]  din        [3];
    logic        mem_req    [3];
    logic [15:0] mem_addr   [3];
    logic        mem_ack    [3] = '{1'b0, 1'b0, 1'b0};
    logic [7:0]  mem_data   [3] = '{8'h00, 8'h00, 8'h00};
    logic        busy       [3];
    logic        overrun    [3];

    int          ack_cnt    [3] = '{0, 0, 0};
    int          req_starts [3] = '{0, 0, 0};
    int          wcnt       [3] = '{0, 0, 0};
    logic        req_prev   [3] = '{1'b0, 1'b0, 1'b0};
    logic [15:0] last_addr  [3] = '{16'h0, 16'h0, 16'h0};
    int          ack_dly   = 0;
    int          late_tok  = 0;
    int          late_done = 0;

    int          n_tests = 0;
    int          n_fail  = 0;

    always #5 clk_sys = ~clk_sys;

    pmd_ioctl_upload #(.ADDR_W(16), .BASE(16'h0000), .SIZE(4), .UPLOAD_INDEX(8'd1)) u_dut0 (
        .clk_sys(clk_sys), .reset_n(reset_n), .save_trig(save_trig),
        .ioctl_upload_req(upload_req[0]), .ioctl_upload(ioctl_upload), .ioctl_index(ioctl_index),
        .ioctl_rd(ioctl_rd), .ioctl_din(din[0]), .mem_req(mem_req[0]), .mem_addr(mem_addr[0]),
        .mem_ack(mem_ack[0]), .mem_data(mem_data[0]), .busy(busy[0]), .overrun(overrun[0])
    );

    pmd_ioctl_upload #(.ADDR_W(16), .BASE(16'hFFFE), .SIZE(4), .UPLOAD_INDEX(8'd1)) u_dut_wrap (
        .clk_sys(clk_sys), .reset_n(reset_n), .save_trig(save_trig),
        .ioctl_upload_req(upload_req[1]), .ioctl_upload(ioctl_upload), .ioctl_index(ioctl_index),
        .ioctl_rd(ioctl_rd), .ioctl_din(din[1]), .mem_req(mem_req[1]), .mem_addr(mem_addr[1]),
        .mem_ack(mem_ack[1]), .mem_data(mem_data[1]), .busy(busy[1]), .overrun(overrun[1])
    );

    pmd_ioctl_upload #(.ADDR_W(16), .BASE(16'h0000), .SIZE(1), .UPLOAD_INDEX(8'd1)) u_dut_one (
        .clk_sys(clk_sys), .reset_n(reset_n), .save_trig(save_trig),
        .ioctl_upload_req(upload_req[2]), .ioctl_upload(ioctl_upload), .ioctl_index(ioctl_index),
        .ioctl_rd(ioctl_rd), .ioctl_din(din[2]), .mem_req(mem_req[2]), .mem_addr(mem_addr[2]),
        .mem_ack(mem_ack[2]), .mem_data(mem_data[2]), .busy(busy[2]), .overrun(overrun[2])
    );

    function automatic logic [7:0] mem_byte(input logic [15:0] a);
        case (a)
            16'h0000: mem_byte = 8'h11;
            16'h0001: mem_byte = 8'h22;
            16'h0002: mem_byte = 8'h33;
            16'h0003: mem_byte = 8'h44;
            16'hFFFE: mem_byte = 8'hA1;
            16'hFFFF: mem_byte = 8'hB2;
            default:  mem_byte = 8'hEE;
        endcase
    endfunction

    // Arbiter model: grant after ack_dly waiting cycles; late_tok injects one stray ack on instance 0.
    always @(negedge clk_sys) begin
        for (int g = 0; g < 3; g++) begin
            mem_ack[g] = 1'b0;
            if (mem_req[g]) begin
                if (!req_prev[g]) req_starts[g]++;
                if (wcnt[g] >= ack_dly) begin
                    mem_ack[g]   = 1'b1;
                    mem_data[g]  = mem_byte(mem_addr[g]);
                    last_addr[g] = mem_addr[g];
                    ack_cnt[g]++;
                    wcnt[g]      = 0;
                end else begin
                    wcnt[g]++;
                end
            end else begin
                wcnt[g] = 0;
            end
            req_prev[g] = mem_req[g];
        end
        if (late_tok != late_done) begin
            mem_ack[0]  = 1'b1;
            mem_data[0] = 8'h99;
            late_done   = late_tok;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk_sys);
    endtask

    task automatic rd_pulse();
        ioctl_rd = 1'b1;
        @(negedge clk_sys);
        ioctl_rd = 1'b0;
    endtask

    task automatic trig_pulse();
        save_trig = 1'b1;
        @(negedge clk_sys);
        save_trig = 1'b0;
    endtask

    task automatic wait_ack(input string tag, input int prev);
        int n = 0;
        while (ack_cnt[0] == prev && n < 100) begin
            @(negedge clk_sys);
            n++;
        end
        check(tag, ack_cnt[0] - prev, 1);
    endtask

    logic [7:0]  exp0 [4] = '{8'h11, 8'h22, 8'h33, 8'h44};
    logic [7:0]  expw [4] = '{8'hA1, 8'hB2, 8'h11, 8'h22};
    logic [15:0] adrw [4] = '{16'hFFFE, 16'hFFFF, 16'h0000, 16'h0001};

    initial begin
        int prev;
        tick(2);
        check("rst_upreq", upload_req[0], 0);
        check("rst_memreq", mem_req[0], 0);
        check("rst_addr0", mem_addr[0], 16'h0000);
        check("rst_addrw", mem_addr[1], 16'hFFFE);
        check("rst_din", din[0], 8'hFF);
        check("rst_busy", busy[0], 0);
        check("rst_ovr", overrun[0], 0);
        reset_n = 1'b1;
        tick(2);

        // Basic save with a wrong index first.
        trig_pulse();
        check("trig_upreq", upload_req[0], 1);
        check("trig_busy", busy[0], 1);
        ioctl_upload = 1'b1;
        ioctl_index  = 8'd2;
        tick(5);
        check("idx_upreq", upload_req[0], 1);
        check("idx_memreq", mem_req[0], 0);
        check("idx_nreq", req_starts[0], 0);
        prev = ack_cnt[0];
        ioctl_index = 8'd1;
        for (int i = 0; i < 4; i++) begin
            wait_ack($sformatf("ack%0d", i), prev);
            @(negedge clk_sys);
            check($sformatf("din0_%0d", i), din[0], exp0[i]);
            check($sformatf("dinw_%0d", i), din[1], expw[i]);
            check($sformatf("addrw_%0d", i), last_addr[1], adrw[i]);
            check($sformatf("ovr_%0d", i), overrun[0], 0);
            if (i == 0) check("one_din", din[2], 8'h11);
            tick(6);
            prev = ack_cnt[0];
            rd_pulse();
            if (i == 0) begin
                @(negedge clk_sys);
                check("one_done_ff", din[2], 8'hFF);
                check("one_nreq", req_starts[2], 1);
            end
        end
        @(negedge clk_sys);
        check("done_din0", din[0], 8'hFF);
        check("done_dinw", din[1], 8'hFF);
        check("done_memreq", mem_req[0], 0);
        check("done_busy", busy[0], 1);
        check("done_nreq", req_starts[0], 4);
        rd_pulse();
        tick(3);
        check("over_din", din[0], 8'hFF);
        check("over_nreq", req_starts[0], 4);
        check("over_ovr", overrun[0], 0);
        ioctl_upload = 1'b0;
        tick(2);
        check("end_busy", busy[0], 0);

        // Arbiter wait, then an early rd during a fetch.
        ack_dly = 20;
        prev = ack_cnt[0];
        trig_pulse();
        ioctl_upload = 1'b1;
        tick(10);
        check("arb_noack", ack_cnt[0] - prev, 0);
        wait_ack("arb_ack", prev);
        @(negedge clk_sys);
        check("arb_din", din[0], 8'h11);
        check("arb_ovr", overrun[0], 0);
        ack_dly = 4;
        prev = ack_cnt[0];
        rd_pulse();
        @(negedge clk_sys);
        ioctl_rd = 1'b1;
        @(negedge clk_sys);
        ioctl_rd = 1'b0;
        check("early_nack", ack_cnt[0] - prev, 0);
        wait_ack("early_ack", prev);
        @(negedge clk_sys);
        check("early_din", din[0], 8'h22);
        check("early_ovr", overrun[0], 1);
        prev = ack_cnt[0];
        rd_pulse();
        wait_ack("next_ack", prev);
        @(negedge clk_sys);
        check("next_din", din[0], 8'h33);

        // Abort while mem_req is high, then a stray ack.
        ack_dly = 30;
        rd_pulse();
        tick(2);
        check("ab_memreq1", mem_req[0], 1);
        check("ab_addr", mem_addr[0], 16'h0003);
        ioctl_upload = 1'b0;
        @(negedge clk_sys);
        check("ab_memreq0", mem_req[0], 0);
        check("ab_busy", busy[0], 0);
        late_tok++;
        tick(3);
        check("late_din", din[0], 8'h33);
        check("late_busy", busy[0], 0);
        check("late_memreq", mem_req[0], 0);
        check("late_ovr", overrun[0], 1);

        // New save clears overrun; reset mid-stream.
        ack_dly = 0;
        trig_pulse();
        check("clr_ovr", overrun[0], 0);
        prev = ack_cnt[0];
        ioctl_upload = 1'b1;
        wait_ack("rs_ack", prev);
        @(negedge clk_sys);
        check("rs_din", din[0], 8'h11);
        rd_pulse();
        reset_n = 1'b0;
        #1;
        check("rs_upreq", upload_req[0], 0);
        check("rs_memreq", mem_req[0], 0);
        check("rs_addr0", mem_addr[0], 16'h0000);
        check("rs_addrw", mem_addr[1], 16'hFFFE);
        check("rs_din_ff", din[0], 8'hFF);
        check("rs_busy", busy[0], 0);
        check("rs_ovr", overrun[0], 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/pmd_ioctl_upload.md
Name: pmd_ioctl_upload

Overview:
- Core-side responder for the HPS file-upload (save) direction of the ioctl channel; the counterpart to the download path that loads ROM-pack images.
- On a save trigger, it requests an upload and streams bytes from a shared synchronous memory (ROM-pack / RMM RAM) out on ioctl_din, one byte per ioctl_rd pulse.
- Sits between hps_io and the PMD85 memory arbiter.
- Memory is accessed through a req/ack handshake so CPU accesses can be given priority.

Parameters:
- ADDR_W, 16, memory-side address width.
- BASE, 16'h0000, memory address of file byte 0.
- SIZE, 32768, file length in bytes (1..2^ADDR_W).
- UPLOAD_INDEX, 8'd1, ioctl_index value that selects this block.

Ports:
- clk_sys  in  1  system clock (18.432 MHz); all logic on rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- save_trig  in  1  one-cycle pulse from OSD/status: start a save.
- ioctl_upload_req  out  1  upload request to hps_io.
- ioctl_upload  in  1  high while HPS runs the upload.
- ioctl_index  in  8  file index of the current transfer.
- ioctl_rd  in  1  one-cycle pulse: HPS has consumed ioctl_din.
- ioctl_din  out  8  byte presented to HPS.
- mem_req  out  1  memory read request; level, held until ack.
- mem_addr  out  ADDR_W  read address; stable while mem_req=1.
- mem_ack  in  1  one-cycle grant; mem_data is valid in the same cycle.
- mem_data  in  8  read data.
- busy  out  1  high in any state except IDLE.
- overrun  out  1  sticky: ioctl_rd arrived while the byte was not ready.

Behaviour:
- Reset (async, reset_n=0):
  - state=IDLE; outputs ioctl_upload_req=0, mem_req=0, mem_addr=BASE, ioctl_din=8'hFF, busy=0, overrun=0.
  - Internal byte counter cnt=0.
- Active transfer means ioctl_upload=1 AND ioctl_index==UPLOAD_INDEX.
- Counter and addressing:
  - cnt is ADDR_W+1 bits wide.
  - mem_addr = BASE + cnt[ADDR_W-1:0], modulo 2^ADDR_W (wraps).
- IDLE:
  - save_trig -> REQ, cnt=0, overrun cleared, ioctl_upload_req=1.
  - save_trig is ignored in every other state.
- REQ:
  - ioctl_upload_req held at 1 until an active transfer is seen; then drop it and go to FETCH.
- FETCH:
  - mem_req=1.
  - On mem_ack: ioctl_din<=mem_data, mem_req<=0 in the same edge, go to READY.
  - Latency to the first byte is 1 cycle plus arbiter wait.
- READY:
  - On ioctl_rd: cnt<=cnt+1.
  - If cnt+1==SIZE: ioctl_din<=8'hFF, go to DONE.
  - Otherwise go to FETCH; mem_req asserts on the next cycle.
- DONE:
  - No memory accesses.
  - ioctl_din=8'hFF.
  - Further ioctl_rd pulses are ignored (HPS over-read returns FF).
- Active transfer ends (in FETCH, READY or DONE):
  - Go to IDLE at once, mem_req<=0.
  - An ack arriving that same cycle is discarded; the arbiter must tolerate the request withdrawal.
- Overrun:
  - ioctl_rd in FETCH sets overrun=1; the pulse is not counted.
  - The in-flight fetch completes normally.
- Simultaneous mem_ack and ioctl_rd in FETCH: the data is latched, overrun=1, next state READY.
- Index mismatch while ioctl_upload=1 (another core file): the block stays in REQ/IDLE and never drives a memory access.
- Reset asserted mid-transfer: immediate return to reset values; the HPS upload aborts from its side.
- Single-byte file (SIZE=1): one fetch, one rd, then DONE.

Test Plan:
- Basic save:
  - BASE=0, SIZE=4, memory 0..3 = 11,22,33,44; save_trig, raise ioctl_upload index 1, mem_ack one cycle after each req; 4 rd pulses spaced 8 cycles.
  - Expect ioctl_din sequence 11,22,33,44, then FF; exactly 4 mem_req; busy until upload drops; overrun=0.
- Arbiter wait: mem_ack delayed 20 cycles; rd issued only after ack -> correct data, no overrun.
- Early rd: rd pulse 2 cycles after a FETCH begins, ack at cycle 5 -> overrun=1, cnt not advanced, byte latched; next rd advances normally.
- Abort: drop ioctl_upload while mem_req=1 -> state IDLE and mem_req=0 on the next edge; a late mem_ack changes nothing.
- Wrong index: ioctl_upload=1 with index 2 after save_trig -> ioctl_upload_req stays 1, mem_req never asserts; switching to index 1 starts the fetch.
- Wrap: BASE=16'hFFFE, SIZE=4 -> mem_addr FFFE, FFFF, 0000, 0001; async reset mid-stream -> every output at its reset value within the reset cycle.
